// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter__pkg: shared types and limits for the L1-to-memory arbiter.
package mem_arbiter__pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWNER__I, OWNER__D} owner_t;
  localparam int MEM_LATENCY__MAX = 7;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between the L1I and L1D caches.
//   clk, rst (async active-low)
//   l1i_to_mem__* / l1d_to_mem__* : req/addr/we/wr_data in, ack/rd_data out
//   mem__addr/wr_data/en/we out, mem__rd_data in (valid MEM_LATENCY cycles after mem__en)
module mem_arbiter
  import mem_arbiter__pkg::*;
#(
  parameter int ADDR_WIDTH  = 61,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l1i_to_mem__req,
  input  logic [ADDR_WIDTH-1:0] l1i_to_mem__addr,
  input  logic                  l1i_to_mem__we,
  input  logic [DATA_WIDTH-1:0] l1i_to_mem__wr_data,
  output logic                  l1i_to_mem__ack,
  output logic [DATA_WIDTH-1:0] l1i_to_mem__rd_data,
  input  logic                  l1d_to_mem__req,
  input  logic [ADDR_WIDTH-1:0] l1d_to_mem__addr,
  input  logic                  l1d_to_mem__we,
  input  logic [DATA_WIDTH-1:0] l1d_to_mem__wr_data,
  output logic                  l1d_to_mem__ack,
  output logic [DATA_WIDTH-1:0] l1d_to_mem__rd_data,
  output logic [ADDR_WIDTH-1:0] mem__addr,
  output logic [DATA_WIDTH-1:0] mem__wr_data,
  output logic                  mem__en,
  output logic                  mem__we,
  input  logic [DATA_WIDTH-1:0] mem__rd_data
);
  state_t                state;
  owner_t                owner, ptr, win;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wd, rd_i, rd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWNER__D;
      ptr   <= OWNER__D;
      cnt   <= '0;
      addr  <= '0;
      we    <= 1'b0;
      wd    <= '0;
      rd_i  <= '0;
      rd_d  <= '0;
    end else begin
      case (state)
        IDLE: if (l1i_to_mem__req || l1d_to_mem__req) begin
          owner <= win;
          addr  <= win == OWNER__D ? l1d_to_mem__addr : l1i_to_mem__addr;
          we    <= win == OWNER__D ? l1d_to_mem__we : l1i_to_mem__we;
          wd    <= win == OWNER__D ? l1d_to_mem__wr_data : l1i_to_mem__wr_data;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt   <= 3'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (!we && owner == OWNER__D) rd_d <= mem__rd_data;
            if (!we && owner == OWNER__I) rd_i <= mem__rd_data;
            state <= DONE;
          end
        end
        DONE: begin
          ptr   <= owner == OWNER__D ? OWNER__I : OWNER__D;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // ptr only breaks ties; a lone requester always wins
    win = (l1i_to_mem__req && l1d_to_mem__req) ? ptr : (l1d_to_mem__req ? OWNER__D : OWNER__I);
    mem__en             = state == ISSUE;
    mem__we             = we;
    mem__addr           = addr;
    mem__wr_data        = wd;
    l1i_to_mem__ack     = state == DONE && owner == OWNER__I;
    l1d_to_mem__ack     = state == DONE && owner == OWNER__D;
    l1i_to_mem__rd_data = rd_i;
    l1d_to_mem__rd_data = rd_d;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-1 and a latency-3 instance.
module tb_mem_arbiter;
  typedef struct {
    logic        side;
    logic [60:0] addr;
    logic        we;
    logic [63:0] wd;
    logic [63:0] rd;
    int          cyc;
  } exp_t;

  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 0, rst;
  logic i_req, d_req, i_we, d_we, ack_i, ack_d, m_en, m_we;
  logic [60:0] i_addr, d_addr, m_addr;
  logic [63:0] i_wd, d_wd, rd_i, rd_d, m_wd, m_rd;
  logic d3_req, i3_ack, d3_ack, m3_en, m3_we;
  logic [60:0] d3_addr, m3_addr;
  logic [63:0] i3_rd, d3_rd, m3_wd, m3_rd, p3a, p3b;
  logic [63:0] mem [256];
  bit          wr_flag [256];
  int          cyc = 0, checks = 0, errors = 0, n_en = 0, n_ack = 0, en_cyc = 0;
  logic [60:0] en_addr;
  logic        en_we;
  logic [63:0] en_wd, mi, md;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .l1i_to_mem__req(i_req), .l1i_to_mem__addr(i_addr), .l1i_to_mem__we(i_we),
    .l1i_to_mem__wr_data(i_wd), .l1i_to_mem__ack(ack_i), .l1i_to_mem__rd_data(rd_i),
    .l1d_to_mem__req(d_req), .l1d_to_mem__addr(d_addr), .l1d_to_mem__we(d_we),
    .l1d_to_mem__wr_data(d_wd), .l1d_to_mem__ack(ack_d), .l1d_to_mem__rd_data(rd_d),
    .mem__addr(m_addr), .mem__wr_data(m_wd), .mem__en(m_en), .mem__we(m_we), .mem__rd_data(m_rd)
  );

  mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .l1i_to_mem__req(1'b0), .l1i_to_mem__addr(61'd0), .l1i_to_mem__we(1'b0),
    .l1i_to_mem__wr_data(64'd0), .l1i_to_mem__ack(i3_ack), .l1i_to_mem__rd_data(i3_rd),
    .l1d_to_mem__req(d3_req), .l1d_to_mem__addr(d3_addr), .l1d_to_mem__we(1'b0),
    .l1d_to_mem__wr_data(64'd0), .l1d_to_mem__ack(d3_ack), .l1d_to_mem__rd_data(d3_rd),
    .mem__addr(m3_addr), .mem__wr_data(m3_wd), .mem__en(m3_en), .mem__we(m3_we), .mem__rd_data(m3_rd)
  );

  // unwritten words read as DEADBEEF_000000aa; data only valid in its one return cycle
  function automatic logic [63:0] mem_rd(input logic [7:0] a);
    return wr_flag[a] ? mem[a] : {32'hDEADBEEF, 24'h0, a};
  endfunction

  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem[m_addr[7:0]]     <= m_wd;
      wr_flag[m_addr[7:0]] <= 1'b1;
    end
    m_rd <= (m_en && !m_we) ? mem_rd(m_addr[7:0]) : BAD;
    p3a  <= (m3_en && !m3_we) ? mem_rd(m3_addr[7:0]) : BAD;
    p3b  <= p3a;
    m3_rd <= p3b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      mi = '0;
      md = '0;
    end
    if (m_en) begin
      n_en++;
      en_cyc  = cyc;
      en_addr = m_addr;
      en_we   = m_we;
      en_wd   = m_wd;
    end
    if (ack_i || ack_d) begin
      n_ack++;
      chk("ack_both", 64'(ack_i && ack_d), 64'(0));
      if (q.size() == 0) chk("ack_unexpected", 64'(1), 64'(0));
      else begin
        e = q.pop_front();
        chk("ack_side", 64'(ack_d), 64'(e.side));
        chk("ack_cyc", 64'(cyc), 64'(e.cyc));
        chk("en_cyc", 64'(en_cyc), 64'(e.cyc - 2));
        chk("en_addr", 64'(en_addr), 64'(e.addr));
        chk("en_we", 64'(en_we), 64'(e.we));
        chk("en_wd", en_wd, e.wd);
        if (!e.we && e.side) md = e.rd;
        if (!e.we && !e.side) mi = e.rd;
        chk("rd_i", rd_i, mi);
        chk("rd_d", rd_d, md);
      end
    end
  end

  task automatic wait_ack();
    bit got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack_i || ack_d) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_req(input logic side, input logic [60:0] a, input logic w,
                        input logic [63:0] wd, input logic [63:0] rd);
    @(posedge clk); #1;
    if (side) begin
      d_addr = a; d_we = w; d_wd = wd; d_req = 1;
    end else begin
      i_addr = a; i_we = w; i_wd = wd; i_req = 1;
    end
    q.push_back('{side, a, w, wd, rd, cyc + 3});
    wait_ack();
    @(posedge clk); #1;
    i_req = 0;
    d_req = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    i_req = 0;
    d_req = 0;
    d3_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int c, acks, a0, e0, ack_c, en_c;
    rst = 0;
    {i_req, d_req, i_we, d_we, d3_req} = '0;
    {i_addr, d_addr, d3_addr} = '0;
    {i_wd, d_wd} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 64'(m_en), 64'(0));
    chk("rst_we", 64'(m_we), 64'(0));
    chk("rst_ack", 64'({ack_i, ack_d}), 64'(0));
    chk("rst_addr", 64'(m_addr), 64'(0));
    chk("rst_wd", m_wd, 64'(0));
    chk("rst_rd_i", rd_i, 64'(0));
    chk("rst_rd_d", rd_d, 64'(0));
    chk("rst3_addr_wd", 64'(m3_addr) | m3_wd, 64'(0));
    rst = 1;

    do_req(1, 61'h10, 0, 64'h0, 64'hDEADBEEF_00000010);
    do_req(0, 61'h20, 1, 64'h1122334455667788, 64'h0);
    do_req(0, 61'h20, 0, 64'h0, 64'h1122334455667788);

    @(posedge clk); #1;
    d_addr = 61'h8; d_we = 0; d_wd = 64'h0; d_req = 1;
    q.push_back('{1'b1, 61'h8, 1'b0, 64'h0, 64'hDEADBEEF_00000008, cyc + 3});
    @(posedge clk); #1;
    d_addr = 61'h9;
    wait_ack();
    @(posedge clk); #1;
    d_req = 0;

    @(posedge clk); #1;
    d3_addr = 61'h40; d3_req = 1;
    c = cyc;
    ack_c = -1;
    en_c = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (m3_en) en_c = cyc;
      if (d3_ack) begin
        ack_c = cyc;
        break;
      end
    end
    chk("l3_en_cyc", 64'(en_c), 64'(c + 1));
    chk("l3_ack_cyc", 64'(ack_c), 64'(c + 5));
    chk("l3_rd_d", d3_rd, 64'hDEADBEEF_00000040);
    chk("l3_rd_i", i3_rd, 64'h0);
    @(posedge clk); #1;
    d3_req = 0;

    @(posedge clk); #1;
    i_addr = 61'h50; i_we = 0; i_req = 1;
    a0 = n_ack;
    repeat (3) @(negedge clk);
    rst = 0;
    i_req = 0;
    #1;
    chk("abort_en", 64'(m_en), 64'(0));
    chk("abort_ack", 64'({ack_i, ack_d}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    chk("abort_no_ack", 64'(n_ack - a0), 64'(0));
    chk("abort_rd_i", rd_i, 64'h0);
    do_req(0, 61'h51, 0, 64'h0, 64'hDEADBEEF_00000051);

    do_reset();
    @(posedge clk); #1;
    i_addr = 61'h31; d_addr = 61'h30; i_we = 0; d_we = 0; i_wd = 0; d_wd = 0;
    i_req = 1; d_req = 1;
    c = cyc;
    e0 = n_en;
    for (int k = 0; k < 4; k++)
      q.push_back('{k[0] ? 1'b0 : 1'b1, k[0] ? 61'h31 : 61'h30, 1'b0, 64'h0,
                    k[0] ? 64'hDEADBEEF_00000031 : 64'hDEADBEEF_00000030, c + 3 + 4 * k});
    acks = 0;
    for (int n = 0; n < 40 && acks < 4; n++) begin
      @(negedge clk);
      if (ack_i || ack_d) acks++;
    end
    @(posedge clk); #1;
    i_req = 0;
    d_req = 0;
    chk("rr_acks", 64'(acks), 64'(4));
    chk("rr_en_count", 64'(n_en - e0), 64'(4));

    repeat (6) @(negedge clk);
    chk("q_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 64-bit memory port (addr/wr_data/rd_data/en/we) between the instruction-side and data-side L1 caches of the jay core. It holds a request/ack handshake with each L1 and sequences one memory access at a time through a small FSM. Winners are chosen by round-robin, and each access waits a fixed memory read latency. It replaces the direct L1-to-memory connection at the top of the core.

## Interface
- ADDR_WIDTH, 61, word (8-byte) address width
- DATA_WIDTH, 64, data width
- MEM_LATENCY, 1, cycles from mem__en to valid mem__rd_data; legal range 1..7
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- l1i_to_mem__req / l1d_to_mem__req  in  1  access request; held high until ack
- l1i_to_mem__addr / l1d_to_mem__addr  in  ADDR_WIDTH  word address
- l1i_to_mem__we / l1d_to_mem__we  in  1  1 = write, 0 = read
- l1i_to_mem__wr_data / l1d_to_mem__wr_data  in  DATA_WIDTH  write data
- l1i_to_mem__ack / l1d_to_mem__ack  out  1  one-cycle completion pulse
- l1i_to_mem__rd_data / l1d_to_mem__rd_data  out  DATA_WIDTH  registered read data, valid with ack
- mem__addr  out  ADDR_WIDTH  to memory
- mem__wr_data  out  DATA_WIDTH  to memory
- mem__en  out  1  memory enable
- mem__we  out  1  memory write enable
- mem__rd_data  in  DATA_WIDTH  from memory

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - No req: stay in IDLE.
  - Otherwise pick a winner:
    - Only one req: that requester wins.
    - Both req: the side named by the priority pointer wins.
  - Latch the winner's addr, we and wr_data, and record the owner; go to ISSUE.
- ISSUE
  - Drive mem__en=1, mem__we=latched we, and the latched addr/wr_data for exactly one cycle.
  - Load the latency counter with MEM_LATENCY; go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1: if the access is a read, capture mem__rd_data into the owner's rd_data register; go to DONE.
- DONE
  - Assert the owner's ack for one cycle.
  - Point the priority pointer at the non-owner side; go to IDLE.
- Writes leave the owner's rd_data register unchanged.
- The non-owner's rd_data register is never modified.
- mem__en=0 in every state except ISSUE. mem__addr, mem__wr_data and mem__we always reflect the latched values.
- Requester inputs are sampled only in IDLE. Changes to addr, we, wr_data or req after the grant are ignored, and the transaction completes and acks regardless.
- A requester that keeps req high in the cycle after its ack issues a new request. That request competes normally, and round-robin gives the other side the grant if both are pending.

## Timing
- Reset (async assert, sync release):
  - State returns to IDLE.
  - mem__en=0, mem__we=0, both acks 0.
  - mem__addr=0, mem__wr_data=0, both rd_data registers 0.
  - Priority pointer set to the data side.
- Reset mid-transaction aborts it: no ack is produced, and mem__en drops immediately.
- Latency: req seen in IDLE at cycle t gives mem__en at t+1 and ack at t+2+MEM_LATENCY (t+3 by default).
- Throughput: one access per 3+MEM_LATENCY cycles (4 by default).
- Counter width: 3 bits.

## Structure
- Package mem_arbiter__pkg contains:
  - state enum state_t {IDLE, ISSUE, WAIT, DONE}
  - requester typedef owner_t {OWNER__I, OWNER__D}
  - localparam MEM_LATENCY__MAX = 7
- No sub-module. One always_ff handles the FSM, latches, pointer and counter; one always_comb drives the outputs.

## Test plan
- Read from d-side only, addr 0x10, memory preloaded with 0xDEADBEEF_00000010 -> mem__en at t+1, l1d_to_mem__ack at t+3 with that data; l1i ack stays 0.
- Write from i-side, addr 0x20, data 0x1122334455667788, then read from i-side of addr 0x20 -> the read returns 0x1122334455667788; i-side rd_data is unchanged during the write ack.
- Both req asserted out of reset and held continuously -> grants alternate d, i, d, i; acks every 4 cycles; no mem__en overlap.
- MEM_LATENCY=3 with a d-side read -> ack at t+5; data is captured from the third cycle after mem__en.
- rst asserted during WAIT -> mem__en=0, ack never pulses, state is IDLE. After release, a new i-side request completes normally.
- d-side changes addr from 0x8 to 0x9 one cycle after the grant -> the memory sees 0x8 and the returned data is that of word 0x8.
